// File: rtl/tx_frame_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// tx_seq_pkg: shared FSM state encoding and default timing constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tx_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } tx_state_e;

  localparam int DEF_GAP_CYCLES     = 10;
  localparam int DEF_TIMEOUT_CYCLES = 1048575;

endpackage

`default_nettype wire

// File: rtl/tx_frame_sequencer_if.sv
// ----------------------------------------------------------------------------
// tx_frame_sequencer_if: frame request / UART handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface tx_frame_sequencer_if #(
  parameter int M = 8
);
  logic         Start;
  logic [M-1:0] DataIn;
  logic         TxDone;
  logic         TxEn;
  logic [7:0]   TxByte;
  logic         Busy;
  logic         FrameDone;
  logic         Triger;
  logic         TxErr;

  modport master (
    output Start, DataIn, TxDone,
    input  TxEn, TxByte, Busy, FrameDone, Triger, TxErr
  );

  modport slave (
    input  Start, DataIn, TxDone,
    output TxEn, TxByte, Busy, FrameDone, Triger, TxErr
  );
endinterface

`default_nettype wire

// File: rtl/tx_frame_sequencer_cycle_timer.sv
// ----------------------------------------------------------------------------
// cycle_timer: clearable up-counter flagging when it holds TERMINAL
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cycle_timer #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 9
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clear,
  input  wire logic i_en,
  output logic      o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_tc = (r_count == WIDTH'(TERMINAL));

endmodule

`default_nettype wire

// File: rtl/tx_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tx_frame_sequencer: sends an M-bit word LSB byte first over a TxEn/TxDone
// UART handshake with an inter-byte gap; TX_TIMEOUT_EN adds a TxDone watchdog.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tx_frame_sequencer
  import tx_seq_pkg::*;
#(
  parameter int M              = 8,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input wire logic             clk,
  input wire logic             RstTx,
  tx_frame_sequencer_if.slave  bus
);

  localparam int NBYTES = M / 8;
  localparam int BCW    = $clog2(NBYTES + 1);

  if ((M % 8) != 0 || M < 8) begin : g_bad_m
    $error("tx_frame_sequencer: M must be a positive multiple of 8");
  end
  if (GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_timing
    $error("tx_frame_sequencer: GAP_CYCLES >= 0 and TIMEOUT_CYCLES >= 1 required");
  end

  tx_state_e      r_state;
  logic [M-1:0]   r_shreg;
  logic [BCW-1:0] r_byte_cnt;
  logic           r_txen;
  logic [7:0]     r_txbyte;
  logic           r_busy;
  logic           r_framedone;
  logic           r_triger;

  logic [M-1:0]   w_shifted;
  logic [BCW-1:0] w_next_cnt;
  logic           w_gap_tc;

  assign w_shifted  = r_shreg >> 8;
  assign w_next_cnt = r_byte_cnt + BCW'(1);

  if (GAP_CYCLES > 0) begin : g_gap
    cycle_timer #(
      .WIDTH    ($clog2(GAP_CYCLES + 1)),
      .TERMINAL (GAP_CYCLES - 1)
    ) u_gap_timer (
      .clk     (clk),
      .rst     (RstTx),
      .i_clear (r_state != GAP),
      .i_en    (r_state == GAP),
      .o_tc    (w_gap_tc)
    );
  end else begin : g_no_gap
    assign w_gap_tc = 1'b1;
  end

`ifdef TX_TIMEOUT_EN
  logic r_txerr;
  logic w_wd_tc;

  cycle_timer #(
    .WIDTH    ($clog2(TIMEOUT_CYCLES + 1)),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_watchdog (
    .clk     (clk),
    .rst     (RstTx),
    .i_clear (r_state != WAIT),
    .i_en    (r_state == WAIT),
    .o_tc    (w_wd_tc)
  );

  assign bus.TxErr = r_txerr;
`else
  assign bus.TxErr = 1'b0;
`endif

  // Outputs are registered on entry to a state so TxEn/FrameDone coincide
  // with the SEND/DONE cycles themselves.
  always_ff @(posedge clk) begin
    if (RstTx) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_byte_cnt  <= '0;
      r_txen      <= 1'b0;
      r_txbyte    <= 8'h00;
      r_busy      <= 1'b0;
      r_framedone <= 1'b0;
      r_triger    <= 1'b0;
`ifdef TX_TIMEOUT_EN
      r_txerr     <= 1'b0;
`endif
    end else begin
      r_txen      <= 1'b0;
      r_triger    <= 1'b0;
      r_framedone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_shreg    <= bus.DataIn;
            r_byte_cnt <= '0;
            r_triger   <= 1'b1;
            r_busy     <= 1'b1;
            r_txen     <= 1'b1;
            r_txbyte   <= bus.DataIn[7:0];
            r_state    <= SEND;
          end
        end
        SEND: r_state <= WAIT;
        WAIT: begin
          if (bus.TxDone) begin
            r_shreg    <= w_shifted;
            r_byte_cnt <= w_next_cnt;
            if (w_next_cnt == BCW'(NBYTES)) begin
              r_framedone <= 1'b1;
              r_state     <= DONE;
            end else if (GAP_CYCLES == 0) begin
              r_txen   <= 1'b1;
              r_txbyte <= w_shifted[7:0];
              r_state  <= SEND;
            end else begin
              r_state <= GAP;
            end
          end
`ifdef TX_TIMEOUT_EN
          else if (w_wd_tc) begin
            r_txerr <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
`endif
        end
        GAP: begin
          if (w_gap_tc) begin
            r_txen   <= 1'b1;
            r_txbyte <= r_shreg[7:0];
            r_state  <= SEND;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.TxEn      = r_txen;
  assign bus.TxByte    = r_txbyte;
  assign bus.Busy      = r_busy;
  assign bus.FrameDone = r_framedone;
  assign bus.Triger    = r_triger;

endmodule

`default_nettype wire
